// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
// Both the top level and the word assembler import this package.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_WIDTH = 10;
  localparam int unsigned FRAME_LEN_WIDTH = 16;
  localparam logic [7:0]  CSUM_SEED       = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // Frame-in-progress states: the loader owns the byte stream here.
  function automatic logic is_busy(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

  // A (re)start is honoured only when no frame is in flight.
  function automatic logic can_arm(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs big-endian stream bytes into 32-bit words and keeps the running XOR checksum.
// word_valid pulses the cycle after the fourth byte of a word is taken.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last_byte_c,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  checksum
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift;

  assign last_byte_c = byte_en && (byte_cnt == 2'd3);

  // The finished word is latched separately so the shifter can keep
  // taking bytes while the write strobe is out.
  always_ff @(posedge clock) begin
    if (clear) begin
      byte_cnt   <= 2'd0;
      shift      <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
      checksum   <= CSUM_SEED;
    end else begin
      word_valid <= last_byte_c;
      if (byte_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {shift[15:0], byte_in};
        checksum <= checksum ^ byte_in;
        if (byte_cnt == 2'd3) begin
          word <= {shift, byte_in};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed-stream program loader: length, instruction words, XOR checksum.
// Writes words into instruction memory and holds the CPU until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = FRAME_LEN_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LEN_WIDTH-1:0]  words_loaded
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  state_e               state;
  state_e               state_nx;
  logic [7:0]           len_hi;
  logic [15:0]          len;
  logic [15:0]          len_full_c;
  logic                 accept_c;
  logic                 arm_c;
  logic                 last_word_c;
  logic                 hold_q;
  logic                 wa_clear_c;
  logic                 wa_byte_en_c;
  logic                 wa_last_byte_c;
  logic                 wa_word_valid;
  logic [31:0]          wa_word;
  logic [7:0]           wa_checksum;

  assign accept_c     = rx_valid && rx_ready;
  assign arm_c        = start && can_arm(state);
  assign len_full_c   = {len_hi, rx_data};
  assign last_word_c  = (words_loaded == LEN_WIDTH'(len - 16'd1));
  assign wa_clear_c   = reset || arm_c;
  assign wa_byte_en_c = accept_c && (state == ST_DATA);

  imem_loader_word_assembler u_word_assembler (
    .clock       (clock),
    .clear       (wa_clear_c),
    .byte_en     (wa_byte_en_c),
    .byte_in     (rx_data),
    .last_byte_c (wa_last_byte_c),
    .word_valid  (wa_word_valid),
    .word        (wa_word),
    .checksum    (wa_checksum)
  );

  // Write port comes straight off the assembler registers; address is the
  // word count, which only advances after the strobe cycle.
  assign imem_we    = wa_word_valid;
  assign imem_wdata = wa_word;
  assign imem_addr  = ADDR_WIDTH'(words_loaded);

  // Restart from DONE re-asserts the hold in the start cycle itself.
  assign cpu_hold = hold_q || (start && (state == ST_DONE));

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (arm_c) state_nx = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept_c) state_nx = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept_c) begin
          if (len_full_c == 16'd0)                  state_nx = ST_CHECK;
          else if (32'(len_full_c) > CAPACITY)      state_nx = ST_ERR;
          else                                      state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wa_last_byte_c && last_word_c) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (accept_c) state_nx = (rx_data == wa_checksum) ? ST_DONE : ST_ERR;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      rx_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      hold_q       <= 1'b1;
      words_loaded <= '0;
      len_hi       <= 8'd0;
      len          <= 16'd0;
    end else begin
      state    <= state_nx;
      rx_ready <= is_busy(state_nx);
      busy     <= is_busy(state_nx);
      done     <= (state_nx == ST_DONE);
      error    <= (state_nx == ST_ERR);
      hold_q   <= (state_nx != ST_DONE);
      if (arm_c) begin
        words_loaded <= '0;
      end else if (wa_word_valid) begin
        words_loaded <= words_loaded + LEN_WIDTH'(1);
      end
      if (accept_c && (state == ST_LEN_HI)) len_hi <= rx_data;
      if (accept_c && (state == ST_LEN_LO)) len    <= len_full_c;
    end
  end

endmodule
